// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage register with a two-entry skid buffer, flush-to-bubble
// and saturating stall/bubble performance counters.
module pipe_stage_buf #(
  parameter int unsigned          DATA_W   = 72,
  parameter logic [DATA_W-1:0]    NOP_DATA = {DATA_W{1'b0}},
  parameter int unsigned          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] main_q, main_nx;
  logic [DATA_W-1:0] skid_q, skid_nx;
  logic              up_xfer;
  logic              dn_xfer;

  // Handshake signals decode from state only, so no ready path runs through this stage.
  assign up_ready = (state != FULL) & ~rst;
  assign dn_valid = (state != EMPTY);
  assign dn_data  = dn_valid ? main_q : NOP_DATA;
  assign up_xfer  = up_valid & up_ready;
  assign dn_xfer  = dn_valid & dn_ready;

  always_comb begin
    occupancy = 2'd0;
    case (state)
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= NOP_DATA;
      skid_q <= NOP_DATA;
    end else begin
      state  <= state_nx;
      main_q <= main_nx;
      skid_q <= skid_nx;
    end
  end

  // Next-state and storage update; flush drops everything including a same-cycle push.
  always_comb begin
    state_nx = state;
    main_nx  = main_q;
    skid_nx  = skid_q;
    if (flush) begin
      state_nx = EMPTY;
      main_nx  = NOP_DATA;
      skid_nx  = NOP_DATA;
    end else begin
      case (state)
        EMPTY: begin
          if (up_xfer) begin
            state_nx = ONE;
            main_nx  = up_data;
          end
        end
        ONE: begin
          if (up_xfer && dn_xfer) begin
            main_nx = up_data;
          end else if (up_xfer) begin
            state_nx = FULL;
            skid_nx  = up_data;
          end else if (dn_xfer) begin
            state_nx = EMPTY;
            main_nx  = NOP_DATA;
          end
        end
        FULL: begin
          if (dn_xfer) begin
            state_nx = ONE;
            main_nx  = skid_q;
            skid_nx  = NOP_DATA;
          end
        end
        default: begin
          state_nx = EMPTY;
          main_nx  = NOP_DATA;
          skid_nx  = NOP_DATA;
        end
      endcase
    end
  end

  // Saturating performance counters; flush leaves them untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (dn_valid && !dn_ready && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (!dn_valid && (bubble_cnt != CNT_MAX)) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Randomized self-checking bench for pipe_stage_buf against a queue-based model
// of a two-deep FIFO stage with flush and saturating counters.
module tb_pipe_stage_buf;

  localparam int unsigned DW = 72;
  localparam int unsigned CW = 16;
  localparam logic [DW-1:0] NOP = 72'hA5_0F0F_0F0F_0F0F_0F0F;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          up_valid;
  logic          up_ready;
  logic [DW-1:0] up_data;
  logic          dn_valid;
  logic          dn_ready;
  logic [DW-1:0] dn_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] bubble_cnt;

  logic       s_rst;
  logic       s_flush;
  logic       s_up_valid;
  logic       s_up_ready;
  logic [7:0] s_up_data;
  logic       s_dn_valid;
  logic       s_dn_ready;
  logic [7:0] s_dn_data;
  logic [1:0] s_occupancy;
  logic [3:0] s_stall_cnt;
  logic [3:0] s_bubble_cnt;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(DW), .NOP_DATA(NOP), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
    .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_buf #(.DATA_W(8), .NOP_DATA(8'h00), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(s_rst), .flush(s_flush),
    .up_valid(s_up_valid), .up_ready(s_up_ready), .up_data(s_up_data),
    .dn_valid(s_dn_valid), .dn_ready(s_dn_ready), .dn_data(s_dn_data),
    .occupancy(s_occupancy), .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: the stage is a FIFO of depth two.
  logic [DW-1:0] q[$];
  int            m_stall  = 0;
  int            m_bubble = 0;
  localparam int CMAX = (1 << CW) - 1;

  task automatic step(input logic r, input logic v, input logic [DW-1:0] d,
                      input logic dr, input logic f, input logic indep);
    logic          e_rdy;
    logic          e_vld;
    logic [DW-1:0] e_data;
    @(negedge clk);
    rst = r; up_valid = v; up_data = d; dn_ready = dr; flush = f;
    #1;
    e_rdy  = !r && (q.size() < 2);
    e_vld  = (q.size() > 0);
    e_data = e_vld ? q[0] : NOP;
    check_val("up_ready", up_ready, e_rdy);
    check_val("dn_valid", dn_valid, e_vld);
    check_val("dn_data", dn_data, e_data);
    check_val("occupancy", occupancy, q.size());
    check_val("stall_cnt", stall_cnt, m_stall);
    check_val("bubble_cnt", bubble_cnt, m_bubble);
    if (indep) begin
      dn_ready = ~dr; up_valid = ~v;
      #1;
      check_val("up_ready_indep", up_ready, e_rdy);
      dn_ready = dr; up_valid = v;
      #1;
    end
    if (r) begin
      q.delete();
      m_stall = 0;
      m_bubble = 0;
    end else begin
      if (e_vld && !dr && m_stall < CMAX) m_stall++;
      if (!e_vld && m_bubble < CMAX) m_bubble++;
      if (f) q.delete();
      else begin
        if (e_vld && dr) void'(q.pop_front());
        if (v && e_rdy) q.push_back(d);
      end
    end
    @(posedge clk);
  endtask

  initial begin
    logic [DW-1:0] rd;
    rst = 1'b1; flush = 1'b0; up_valid = 1'b0; up_data = '0; dn_ready = 1'b0;
    s_rst = 1'b1; s_flush = 1'b0; s_up_valid = 1'b0; s_up_data = '0; s_dn_ready = 1'b0;

    // Saturation on a 4-bit counter instance, main DUT held in reset meanwhile.
    repeat (2) @(posedge clk);
    @(negedge clk);
    s_rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_val("sat_bubble_5", s_bubble_cnt, 4'd5);
    check_val("sat_stall_0", s_stall_cnt, 4'd0);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check_val("sat_bubble_20", s_bubble_cnt, 4'd15);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_val("sat_bubble_hold", s_bubble_cnt, 4'd15);
    check_val("sat_dn_valid", s_dn_valid, 1'b0);

    // Reset with upstream pushing.
    repeat (3) step(1'b1, 1'b1, DW'(8'hAA), 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Streaming with dn_ready held high.
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, DW'(i), 1'b1, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Back-pressure then release.
    step(1'b0, 1'b1, DW'(8'h10), 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, DW'(8'h11), 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1, DW'(8'h12), 1'b0, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b1, DW'(8'h12), 1'b1, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Flush while full with a competing push.
    step(1'b0, 1'b1, DW'(8'h20), 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, DW'(8'h21), 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, DW'(8'h55), 1'b0, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0, DW'(8'h55), 1'b1, 1'b0, 1'b0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 10000; i++) begin
      rd = {$urandom, $urandom, 8'($urandom)};
      step(($urandom_range(0, 999) == 0),
           ($urandom_range(0, 3) != 0),
           rd,
           ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 15) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised, handshake-based pipeline stage register for the RV32 core that replaces hard-wired inter-stage latches driven by a global stall vector. It carries an opaque DATA_W-bit payload (write enable, register address, write data, ALU op, memory address, or any other stage bundle) between two pipeline stages with valid/ready flow control. A two-entry skid buffer gives full throughput with no combinational ready path. Flush inserts bubbles, and saturating counters report stall and bubble cycles for performance analysis.

## Interface
Parameters:
- DATA_W, 72, payload width in bits.
- NOP_DATA, {DATA_W{1'b0}}, payload value presented and stored when the stage holds no instruction (bubble encoding).
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous kill of all held entries.
- up_valid  in  1  upstream stage presents a payload.
- up_ready  out  1  this stage can accept a payload this cycle.
- up_data  in  DATA_W  upstream payload.
- dn_valid  out  1  this stage presents a payload downstream.
- dn_ready  in  1  downstream stage accepts this cycle.
- dn_data  out  DATA_W  downstream payload; NOP_DATA when dn_valid=0.
- occupancy  out  2  entries held: 0, 1 or 2.
- stall_cnt  out  CNT_W  cycles with dn_valid=1 and dn_ready=0, saturating.
- bubble_cnt  out  CNT_W  cycles with dn_valid=0, saturating.

## Operation
- Storage: main register (drives dn_data) and skid register; state EMPTY (occ 0), ONE (main valid), FULL (main+skid valid).
- Up transfer = up_valid & up_ready; down transfer = dn_valid & dn_ready.
- up_ready = (state != FULL) & !rst; decoded from state only, with no path from dn_ready or up_valid.
- dn_valid = (state != EMPTY); dn_data = main when valid, otherwise NOP_DATA.
- EMPTY: up transfer -> ONE, main <= up_data; else stay.
- ONE: up & down -> ONE, main <= up_data; up only -> FULL, skid <= up_data; down only -> EMPTY, main <= NOP_DATA; neither -> stay.
- FULL: down -> ONE, main <= skid, skid <= NOP_DATA; else stay (up_ready=0, so no up transfer is possible).
- Payload order is strictly FIFO; no payload is duplicated or dropped except by flush/rst.
- Priority: rst > flush > normal transitions.
- flush: state -> EMPTY, main and skid <= NOP_DATA; any up transfer in the same cycle is discarded; a down transfer in the same cycle still counts as consumed downstream.
- Counters: stall_cnt += 1 when dn_valid & !dn_ready; bubble_cnt += 1 when !dn_valid; both hold at 2^CNT_W-1; neither counts while rst=1; flush does not clear them.
- Reset: state EMPTY, main = skid = NOP_DATA, occupancy 0, dn_valid 0, dn_data NOP_DATA, up_ready 0 during rst, stall_cnt = bubble_cnt = 0.

## Timing
- Latency: payload accepted at edge N appears on dn_data/dn_valid after edge N (visible cycle N+1), registered.
- Throughput: one payload per cycle sustained when dn_ready=1.
- Back-pressure: after dn_ready drops, at most one further payload is accepted (into skid); up_ready falls the cycle after FULL is entered.
- Release: the first cycle dn_ready=1 in FULL drains main; up_ready=1 the following cycle.
- First cycle after rst deasserts: up_ready=1, dn_valid=0.
- Simultaneous flush and up_valid: up_ready may read 1, but the payload is dropped; dn_valid=0 next cycle.

## Test plan
- Reset: hold rst 3 cycles with up_valid=1, up_data=0xAA -> dn_valid=0, dn_data=NOP_DATA, up_ready=0, counters 0; after release, up_ready=1.
- Streaming: dn_ready=1, push 0x01..0x08 back-to-back -> dn_data 0x01..0x08 on consecutive cycles, one-cycle latency, occupancy ≤1, stall_cnt=0.
- Back-pressure: push 0x10, 0x11, 0x12 continuously with dn_ready=0 from the second push -> occupancy 2, up_ready=0, 0x12 held upstream; raise dn_ready -> outputs 0x10, 0x11, 0x12 in order; stall_cnt equals the number of dn_ready=0 cycles with dn_valid=1.
- Flush while FULL with up_valid=1, up_data=0x55 -> next cycle dn_valid=0, dn_data=NOP_DATA, occupancy 0, 0x55 never appears.
- Saturation: CNT_W=4, idle 20 cycles after reset -> bubble_cnt=15 and stays 15.
- Random: random up_valid/dn_ready/flush for 10k cycles against a FIFO scoreboard -> order preserved, no loss outside flush, up_ready never depends combinationally on dn_ready.
